// File: rtl/wb_branch_stage_pkg.sv
// Shared encodings and stage-register layout for the writeback / branch-resolution stage.
// Imported by wb_branch_stage and branch_resolve.
package wb_branch_stage_pkg;

  localparam logic [1:0] MD_F     = 2'd0;
  localparam logic [1:0] MD_DATA  = 2'd1;
  localparam logic [1:0] MD_SLT   = 2'd2;
  localparam logic [1:0] MD_F_ALT = 2'd3;

  localparam logic [1:0] BS_NONE = 2'd0;
  localparam logic [1:0] BS_COND = 2'd1;
  localparam logic [1:0] BS_JBRA = 2'd2;
  localparam logic [1:0] BS_JRAA = 2'd3;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BRA = 2'd1;
  localparam logic [1:0] PCSEL_RAA = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN = 2'd0;
  localparam state_t ST_SQ1 = 2'd1;
  localparam state_t ST_SQ2 = 2'd2;

  typedef struct packed {
    logic [31:0] bus_d;
    logic [4:0]  da;
    logic        rw;
    logic        wb_valid;
  } wb_regs_t;

  function automatic logic [31:0] wb_select(input logic [1:0] md, input logic [31:0] f,
                                             input logic [31:0] data, input logic nxorv);
    logic [31:0] sel;
    case (md)
      MD_DATA: sel = data;
      MD_SLT:  sel = {31'b0, nxorv};
      default: sel = f;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_branch_stage_branch_resolve.sv
// Combinational branch/jump resolution: decides whether the transfer is taken
// and which PC source and target the fetch stage should use.
module branch_resolve
  import wb_branch_stage_pkg::*;
(
  input  logic [1:0]  bs_i,
  input  logic        ps_i,
  input  logic        z_i,
  input  logic [15:0] bra_i,
  input  logic [15:0] raa_i,
  output logic        taken_o,
  output logic [1:0]  pcsel_o,
  output logic [15:0] target_o
);

  always_comb begin
    taken_o  = 1'b0;
    pcsel_o  = PCSEL_SEQ;
    target_o = 16'h0000;
    case (bs_i)
      // PS selects polarity: Z ^ PS is true for BZ with Z=1 or BNZ with Z=0
      BS_COND: begin
        if (z_i ^ ps_i) begin
          taken_o  = 1'b1;
          pcsel_o  = PCSEL_BRA;
          target_o = bra_i;
        end
      end
      BS_JBRA: begin
        taken_o  = 1'b1;
        pcsel_o  = PCSEL_BRA;
        target_o = bra_i;
      end
      BS_JRAA: begin
        taken_o  = 1'b1;
        pcsel_o  = PCSEL_RAA;
        target_o = raa_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_branch_stage.sv
// Writeback and branch-resolution stage: registers execute results, selects the
// writeback value, resolves transfers and squashes the two wrong-path slots behind them.
module wb_branch_stage
  import wb_branch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [4:0]  DA_in,
  input  logic        RW_in,
  input  logic [1:0]  MD_in,
  input  logic [1:0]  BS_in,
  input  logic        PS_in,
  input  logic [31:0] F,
  input  logic [31:0] data,
  input  logic        Z,
  input  logic        NXORV,
  input  logic [15:0] BrA,
  input  logic [15:0] RAA,
  output logic [31:0] BUS_D,
  output logic [4:0]  DA,
  output logic        RW,
  output logic        wb_valid,
  output logic [1:0]  PCSEL,
  output logic [15:0] PC_TGT,
  output logic        flush,
  output logic [31:0] retired
);

  logic        accept;
  logic        commit;
  logic        br_taken;
  logic [1:0]  br_pcsel;
  logic [15:0] br_target;

  state_t      state_q, state_d;
  wb_regs_t    wb_q, wb_d;
  logic [1:0]  pcsel_q, pcsel_d;
  logic [15:0] tgt_q, tgt_d;
  logic [31:0] retired_q, retired_d;

  branch_resolve u_branch_resolve (
    .bs_i     (BS_in),
    .ps_i     (PS_in),
    .z_i      (Z),
    .bra_i    (BrA),
    .raa_i    (RAA),
    .taken_o  (br_taken),
    .pcsel_o  (br_pcsel),
    .target_o (br_target)
  );

  assign accept = ~stall;
  assign commit = accept & in_valid & (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    pcsel_d   = PCSEL_SEQ;
    tgt_d     = tgt_q;
    retired_d = retired_q;
    if (accept) begin
      wb_d.bus_d    = wb_select(MD_in, F, data, NXORV);
      wb_d.da       = DA_in;
      wb_d.rw       = RW_in & commit;
      wb_d.wb_valid = commit;
      if (commit) begin
        retired_d = retired_q + 32'd1;
      end
      // Wrong-path slots advance the squash on every accept, bubbles included.
      case (state_q)
        ST_RUN: begin
          if (commit && br_taken) begin
            pcsel_d = br_pcsel;
            tgt_d   = br_target;
            state_d = ST_SQ1;
          end
        end
        ST_SQ1:  state_d = ST_SQ2;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wb_q      <= '0;
      pcsel_q   <= PCSEL_SEQ;
      tgt_q     <= 16'h0000;
      retired_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      wb_q      <= wb_d;
      pcsel_q   <= pcsel_d;
      tgt_q     <= tgt_d;
      retired_q <= retired_d;
    end
  end

  assign BUS_D    = wb_q.bus_d;
  assign DA       = wb_q.da;
  assign RW       = wb_q.rw;
  assign wb_valid = wb_q.wb_valid;
  assign PCSEL    = pcsel_q;
  assign PC_TGT   = tgt_q;
  assign flush    = (state_q != ST_RUN);
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_branch_stage.sv
// Directed plus randomized bench for wb_branch_stage against a behavioural model
// that tracks outstanding squash slots and a commit count.
module tb_wb_branch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, in_valid, RW_in, PS_in, Z, NXORV;
  logic [4:0]  DA_in;
  logic [1:0]  MD_in, BS_in;
  logic [31:0] F, data;
  logic [15:0] BrA, RAA;
  logic [31:0] BUS_D, retired;
  logic [4:0]  DA;
  logic        RW, wb_valid, flush;
  logic [1:0]  PCSEL;
  logic [15:0] PC_TGT;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  logic [31:0] m_bus, m_ret;
  logic [4:0]  m_da;
  logic        m_rw, m_wbv;
  logic [1:0]  m_pcsel;
  logic [15:0] m_tgt;
  int          m_sq;

  always #5 clk = ~clk;

  wb_branch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
    .DA_in(DA_in), .RW_in(RW_in), .MD_in(MD_in), .BS_in(BS_in), .PS_in(PS_in),
    .F(F), .data(data), .Z(Z), .NXORV(NXORV), .BrA(BrA), .RAA(RAA),
    .BUS_D(BUS_D), .DA(DA), .RW(RW), .wb_valid(wb_valid), .PCSEL(PCSEL),
    .PC_TGT(PC_TGT), .flush(flush), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Predict the stage outputs from the current inputs, clock once, compare.
  task automatic tick();
    bit live;
    if (reset) begin
      m_bus = 0; m_da = 0; m_rw = 0; m_wbv = 0; m_pcsel = 0; m_tgt = 0; m_ret = 0; m_sq = 0;
    end else if (stall) begin
      m_pcsel = 0;
    end else begin
      live = (m_sq == 0) && in_valid;
      if (m_sq > 0) m_sq = m_sq - 1;
      if (MD_in == 2'd1)      m_bus = data;
      else if (MD_in == 2'd2) m_bus = {31'b0, NXORV};
      else                    m_bus = F;
      m_da = DA_in;
      m_rw = RW_in && live;
      m_wbv = live;
      m_pcsel = 0;
      if (live) begin
        m_ret = m_ret + 1;
        if ((BS_in == 2'd1 && ((PS_in == 1'b0 && Z == 1'b1) || (PS_in == 1'b1 && Z == 1'b0)))
            || BS_in == 2'd2) begin
          m_pcsel = 1; m_tgt = BrA; m_sq = 2;
        end else if (BS_in == 2'd3) begin
          m_pcsel = 2; m_tgt = RAA; m_sq = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("BUS_D", BUS_D, m_bus);
    chk("DA", {27'b0, DA}, {27'b0, m_da});
    chk("RW", {31'b0, RW}, {31'b0, m_rw});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_wbv});
    chk("PCSEL", {30'b0, PCSEL}, {30'b0, m_pcsel});
    chk("PC_TGT", {16'b0, PC_TGT}, {16'b0, m_tgt});
    chk("flush", {31'b0, flush}, {31'b0, (m_sq > 0)});
    chk("retired", retired, m_ret);
  endtask

  task automatic instr(input logic [1:0] md, input logic [1:0] bs, input logic ps, input logic z);
    in_valid = 1; RW_in = 1; MD_in = md; BS_in = bs; PS_in = ps; Z = z;
    tick();
  endtask

  initial begin
    logic [31:0] ret_snap;
    reset = 1; stall = 0; in_valid = 0; DA_in = 5'd3; RW_in = 0; MD_in = 0; BS_in = 0;
    PS_in = 0; F = 32'h1234_5678; data = 32'hCAFE_F00D; Z = 0; NXORV = 1;
    BrA = 16'h0040; RAA = 16'h1234;
    m_sq = 0;
    tick(); tick();
    chk("rst_bus", BUS_D, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    reset = 0;

    // writeback select sweep
    instr(2'd0, 2'd0, 0, 0); chk("md0", BUS_D, 32'h1234_5678);
    instr(2'd1, 2'd0, 0, 0); chk("md1", BUS_D, 32'hCAFE_F00D);
    instr(2'd2, 2'd0, 0, 0); chk("md2", BUS_D, 32'h0000_0001);
    instr(2'd3, 2'd0, 0, 0); chk("md3", BUS_D, 32'h1234_5678);
    chk("md_rw", {31'b0, RW}, 32'h1);

    // BZ taken, two squashed slots (one of them a jump), third commits
    instr(2'd0, 2'd1, 0, 1);
    chk("bz_pcsel", {30'b0, PCSEL}, 32'd1);
    chk("bz_tgt", {16'b0, PC_TGT}, 32'h0040);
    instr(2'd0, 2'd2, 0, 0); chk("sq1_rw", {31'b0, RW}, 32'h0);
    instr(2'd0, 2'd0, 0, 0); chk("sq2_pcsel", {30'b0, PCSEL}, 32'h0);
    instr(2'd0, 2'd0, 0, 0); chk("after_sq_valid", {31'b0, wb_valid}, 32'h1);

    // BNZ with Z=1: not taken
    ret_snap = retired;
    instr(2'd0, 2'd1, 1, 1);
    chk("bnz_flush", {31'b0, flush}, 32'h0);
    chk("bnz_ret", retired, ret_snap + 1);

    // JR then stall inside SQ1
    instr(2'd0, 2'd3, 0, 0);
    chk("jr_pcsel", {30'b0, PCSEL}, 32'd2);
    chk("jr_tgt", {16'b0, PC_TGT}, 32'h1234);
    ret_snap = retired;
    stall = 1;
    tick(); tick(); tick();
    chk("stall_flush", {31'b0, flush}, 32'h1);
    chk("stall_ret", retired, ret_snap);
    stall = 0;
    instr(2'd0, 2'd0, 0, 0);
    instr(2'd0, 2'd0, 0, 0);
    chk("jr_resume", {31'b0, flush}, 32'h0);

    // reset while in SQ2
    instr(2'd0, 2'd2, 0, 0);
    instr(2'd0, 2'd0, 0, 0);
    reset = 1; tick(); reset = 0;
    chk("rst_sq_ret", retired, 32'h0);
    instr(2'd0, 2'd0, 0, 0);
    chk("rst_sq_commit", {31'b0, wb_valid}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 79) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      DA_in    = 5'($urandom);
      RW_in    = 1'($urandom);
      MD_in    = 2'($urandom);
      BS_in    = 2'($urandom);
      PS_in    = 1'($urandom);
      Z        = 1'($urandom);
      NXORV    = 1'($urandom);
      F        = $urandom;
      data     = $urandom;
      BrA      = 16'($urandom);
      RAA      = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
